// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Steps a 4-to-16 decoder's select through ROWS rows, each row
//               a blanking interval (en=0) followed by a dwell interval (en=1).
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int ROWS  = 16,
    parameter int DWELL = 8,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    output logic [3:0] d,
    output logic       en,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLNK  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [15:0] c_blank_cnt = 16'(BLANK);
    localparam logic [15:0] c_dwell_cnt = 16'(DWELL);
    localparam logic [3:0]  c_last_row  = 4'(ROWS - 1);

    // Every row starts here; with no blanking the row goes straight to DRIVE.
    localparam state_t      c_row_state = (BLANK != 0) ? ST_BLNK : ST_DRIVE;
    localparam logic [15:0] c_row_cnt   = (BLANK != 0) ? c_blank_cnt : c_dwell_cnt;
    localparam logic        c_row_en    = (BLANK == 0);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_d, w_d_nxt;
    logic        r_en, w_en_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_frame_done, w_frame_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 16'd0;
            r_d          <= 4'd0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_d          <= w_d_nxt;
            r_en         <= w_en_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_d_nxt          = r_d;
        w_en_nxt         = r_en;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = c_row_state;
                    w_cnt_nxt   = c_row_cnt;
                    w_en_nxt    = c_row_en;
                    w_d_nxt     = 4'd0;
                    w_busy_nxt  = 1'b1;
                end
            end

            ST_BLNK: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_d_nxt     = 4'd0;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt <= 16'd1) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = c_dwell_cnt;
                    w_en_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end
            end

            ST_DRIVE: begin
                if (stop) begin
                    // Abort wins over a coinciding frame end: no frame_done.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_d_nxt     = 4'd0;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt > 16'd1) begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end else if (r_d != c_last_row) begin
                    w_state_nxt = c_row_state;
                    w_cnt_nxt   = c_row_cnt;
                    w_en_nxt    = c_row_en;
                    w_d_nxt     = r_d + 4'd1;
                end else begin
                    w_frame_done_nxt = 1'b1;
                    w_d_nxt          = 4'd0;
                    if (cont) begin
                        w_state_nxt = c_row_state;
                        w_cnt_nxt   = c_row_cnt;
                        w_en_nxt    = c_row_en;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 16'd0;
                        w_en_nxt    = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 16'd0;
                w_d_nxt     = 4'd0;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign d          = r_d;
    assign en         = r_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
